random_choose_weighted_n: RTL and testbench
===========================================

// Module: random_choose_weighted_n
// PURPOSE
//  Draws one item index from NUM_ITEMS weighted items; P(item i) = w[i]/sum(w).
//  Parametrised successor of the fixed 4-way chooser: item count and weight width are
//  parameters, with start/valid handshake, stall, zero-total error and seed reload.
//  Sits in the MCMC solver and picks the next segment/variable to move each iteration.
// PARAMETERS
//  NUM_ITEMS  4   number of weighted items, >=2
//  WIDTH      32  bits per weight and per random sample, 1..32
// PORTS
//  in_clock         in   1                  single clock, rising edge
//  in_reset         in   1                  asynchronous, active-high reset
//  in_enable        in   1                  0 = freeze FSM and LFSR (stall)
//  in_seed_load     in   1                  load in_seed into LFSR (idle or busy)
//  in_seed          in   32                 LFSR seed; 0 is replaced by 1
//  in_start         in   1                  request a draw; accepted only in IDLE
//  in_weights       in   NUM_ITEMS*WIDTH    item i at [i*WIDTH +: WIDTH]
//  out_busy         out  1                  high in every state except IDLE
//  out_valid        out  1                  one-cycle pulse, result valid
//  out_index        out  $clog2(NUM_ITEMS)  chosen item, held until next out_valid
//  out_error        out  1                  with out_valid: total weight was zero
// BEHAVIOUR
//  Reset: FSM=IDLE, LFSR=1, outputs 0, weight/cumsum regs 0.
//  LFSR: 32-bit Galois, poly 0x80200003, steps every cycle in_enable=1; r = lfsr[WIDTH-1:0].
//  in_seed_load has priority over stepping; applies even when in_enable=0.
//  FSM (advances only when in_enable=1):
//   IDLE:   in_start=1 at edge T -> capture in_weights, acc=0, go ACCUM.
//   ACCUM:  cycles T+1..T+N: acc+=w[i], cum[i]=acc; after i=N-1 -> DRAW.
//   DRAW:   T+N+1: total==0 -> DONE with error; else target=(r*total)>>WIDTH, -> SEARCH.
//   SEARCH: index k checked at T+N+2+k; first k with target<cum[k] -> DONE, out_index=k.
//   DONE:   out_valid=1 one cycle (out_error per DRAW), -> IDLE.
//  Latency start->out_valid: 2+N+k+1 edges; worst 2N+2 (k=N-1).
//  Widths: SUMW=WIDTH+$clog2(NUM_ITEMS); product WIDTH+SUMW bits, no truncation.
//  target<total always, so SEARCH always hits; zero-weight items never chosen.
//  Boundaries: in_start while busy ignored; in_enable=0 mid-draw holds state/outputs,
//   out_valid held high if stalled in DONE; reset mid-draw -> IDLE, no out_valid;
//   error draw: out_index=0, out_error=1; in_weights only sampled at start.
// CONFIGURATION
//  RC_ITEM_MASK_EN defined: extra port in_mask (in, NUM_ITEMS), captured at start;
//   masked-off item's weight treated as 0 in ACCUM.
//  Undefined: no in_mask port; all items participate.
// STRUCTURE
//  Package rc_pkg: FSM state enum (IDLE,ACCUM,DRAW,SEARCH,DONE), LFSR poly constant,
//   LFSR reset value.
//  Sub-module rc_lfsr32: seed load, enable-gated step, zero-seed substitution.
//  Top: FSM, weight/cumsum register file, multiply-shift, sequential search.
// TESTING
//  N=4,W=32, weights 2,4,2,0, seed 1, 8000 draws -> counts ~2000/4000/2000/0 +/-5%, idx3=0.
//  All weights 0 -> out_valid after N+3 edges, out_error=1, out_index=0.
//  Only w[3]=5 -> out_index=3 every draw, out_valid exactly 10 edges after start.
//  Stall: drop in_enable 3 cycles in SEARCH -> out_valid 3 cycles later, same index.
//  in_reset pulse mid-ACCUM -> busy=0, no out_valid; next draw normal.
//  Seed load 0 -> LFSR=1; RC_ITEM_MASK_EN, mask=4'b1011 -> item 2 never chosen.

Source files
------------

// File: rtl/random_choose_weighted_n_pkg.sv
// Shared types and constants for the weighted chooser: FSM states, LFSR polynomial
// and reset value, and the single-step Galois LFSR function.
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAW   = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } rc_state_e;

  localparam logic [31:0] RC_LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] RC_LFSR_RESET = 32'h0000_0001;

  // Right-shifting Galois step: the bit shifted out selects the feedback taps.
  function automatic logic [31:0] rc_lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ RC_LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/random_choose_weighted_n_if.sv
// Control/result bundle of the weighted chooser. Optional in_mask exists only when
// RC_ITEM_MASK_EN is defined.
interface random_choose_weighted_n_if #(
  parameter int NUM_ITEMS = 4,
  parameter int WIDTH     = 32
);
  import rc_pkg::*;

  localparam int IDXW = $clog2(NUM_ITEMS);

  // Handshake: in_start is a request that is taken only on an enabled edge while
  // out_busy is low; out_busy is the inverse of ready. out_valid marks the result
  // cycle (out_index/out_error valid), lasts one enabled cycle and stays high while
  // stalled. out_index/out_error then hold until the next result.
  logic                       in_enable;
  logic                       in_seed_load;
  logic [31:0]                in_seed;
  logic                       in_start;
  logic [NUM_ITEMS*WIDTH-1:0] in_weights;
`ifdef RC_ITEM_MASK_EN
  logic [NUM_ITEMS-1:0]       in_mask;
`endif
  logic                       out_busy;
  logic                       out_valid;
  logic [IDXW-1:0]            out_index;
  logic                       out_error;
  rc_state_e                  dbg_state;

  modport master (
`ifdef RC_ITEM_MASK_EN
    output in_mask,
`endif
    output in_enable, in_seed_load, in_seed, in_start, in_weights,
    input  out_busy, out_valid, out_index, out_error, dbg_state
  );

  modport slave (
`ifdef RC_ITEM_MASK_EN
    input  in_mask,
`endif
    input  in_enable, in_seed_load, in_seed, in_start, in_weights,
    output out_busy, out_valid, out_index, out_error, dbg_state
  );

endinterface

// File: rtl/random_choose_weighted_n_lfsr.sv
// 32-bit Galois LFSR with seed load (priority over stepping, ignores enable),
// enable-gated stepping and zero-seed substitution.
module rc_lfsr32
  import rc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        seed_load_i,
  input  logic [31:0] seed_i,
  output logic [31:0] lfsr_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load_i) begin
      lfsr_d = (seed_i == 32'd0) ? 32'd1 : seed_i;
    end else if (en_i) begin
      lfsr_d = rc_lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= RC_LFSR_RESET;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/random_choose_weighted_n.sv
// Weighted random chooser: P(item i) = w[i]/sum(w). Optional per-item mask when
// RC_ITEM_MASK_EN is defined.
module random_choose_weighted_n
  import rc_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int WIDTH     = 32
) (
  input  logic                       in_clock,
  input  logic                       in_reset,
  random_choose_weighted_n_if.slave  bus
);

  localparam int IDXW  = $clog2(NUM_ITEMS);
  localparam int SUMW  = WIDTH + $clog2(NUM_ITEMS);
  localparam int PRODW = WIDTH + SUMW;
  localparam logic [IDXW-1:0] LAST_ITEM = IDXW'(NUM_ITEMS - 1);

  rc_state_e        state_q, state_d;
  logic [WIDTH-1:0] w_q   [NUM_ITEMS];
  logic [WIDTH-1:0] w_d   [NUM_ITEMS];
  logic [SUMW-1:0]  cum_q [NUM_ITEMS];
  logic [SUMW-1:0]  cum_d [NUM_ITEMS];
  logic [SUMW-1:0]  acc_q, acc_d;
  logic [SUMW-1:0]  target_q, target_d;
  logic [IDXW-1:0]  item_q, item_d;
  logic [IDXW-1:0]  index_q, index_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;

  logic [31:0]      lfsr;
  logic [WIDTH-1:0] add_w;
  logic [SUMW-1:0]  acc_sum;
  logic [PRODW-1:0] product;
  logic [PRODW-1:0] scaled;

  rc_lfsr32 u_lfsr (
    .clk_i       (in_clock),
    .rst_i       (in_reset),
    .en_i        (bus.in_enable),
    .seed_load_i (bus.in_seed_load),
    .seed_i      (bus.in_seed),
    .lfsr_o      (lfsr)
  );

`ifdef RC_ITEM_MASK_EN
  logic [NUM_ITEMS-1:0] mask_q, mask_d;

  always_comb begin
    add_w = w_q[item_q];
    if (!mask_q[item_q]) add_w = '0;
  end
`else
  always_comb begin
    add_w = w_q[item_q];
  end
`endif

  // Full-width product so (r * total) >> WIDTH is exact and always below total.
  always_comb begin
    acc_sum = acc_q + {{(SUMW-WIDTH){1'b0}}, add_w};
    product = {{SUMW{1'b0}}, lfsr[WIDTH-1:0]} * {{WIDTH{1'b0}}, acc_q};
    scaled  = product >> WIDTH;
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cum_d    = cum_q;
    acc_d    = acc_q;
    target_d = target_q;
    item_d   = item_q;
    index_d  = index_q;
    zero_d   = zero_q;
    error_d  = error_q;
`ifdef RC_ITEM_MASK_EN
    mask_d   = mask_q;
`endif
    if (bus.in_enable) begin
      case (state_q)
        IDLE: begin
          if (bus.in_start) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
              w_d[i] = bus.in_weights[i*WIDTH +: WIDTH];
            end
`ifdef RC_ITEM_MASK_EN
            mask_d = bus.in_mask;
`endif
            acc_d   = '0;
            item_d  = '0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          acc_d         = acc_sum;
          cum_d[item_q] = acc_sum;
          if (item_q == LAST_ITEM) begin
            item_d  = '0;
            state_d = DRAW;
          end else begin
            item_d = item_q + IDXW'(1);
          end
        end
        DRAW: begin
          zero_d   = (acc_q == '0);
          target_d = scaled[SUMW-1:0];
          item_d   = '0;
          state_d  = SEARCH;
        end
        // Zero-total draws finish in the first search cycle, like a k=0 hit.
        SEARCH: begin
          if (zero_q) begin
            index_d = '0;
            error_d = 1'b1;
            state_d = DONE;
          end else if ((target_q < cum_q[item_q]) || (item_q == LAST_ITEM)) begin
            index_d = item_q;
            error_d = 1'b0;
            state_d = DONE;
          end else begin
            item_d = item_q + IDXW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      target_q <= '0;
      item_q   <= '0;
      index_q  <= '0;
      zero_q   <= 1'b0;
      error_q  <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        w_q[i]   <= '0;
        cum_q[i] <= '0;
      end
`ifdef RC_ITEM_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      target_q <= target_d;
      item_q   <= item_d;
      index_q  <= index_d;
      zero_q   <= zero_d;
      error_q  <= error_d;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        w_q[i]   <= w_d[i];
        cum_q[i] <= cum_d[i];
      end
`ifdef RC_ITEM_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign bus.out_busy  = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_index = index_q;
  assign bus.out_error = error_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_random_choose_weighted_n.sv
// Bench for random_choose_weighted_n (N=4, W=32): directed draws with hand-computed
// results, a cycle-level reference model compared every cycle, and a distribution run.
module tb_random_choose_weighted_n;
  import rc_pkg::*;

  localparam int NI   = 4;
  localparam int W    = 32;
  localparam int IDXW = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 0;

  random_choose_weighted_n_if #(.NUM_ITEMS(NI), .WIDTH(W)) rc_if ();

  random_choose_weighted_n #(.NUM_ITEMS(NI), .WIDTH(W)) dut (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (rc_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_lfsr;
  logic [31:0] m_r;
  longint      m_w [NI];
  bit          m_busy, m_valid, m_error, m_zero;
  int          m_cnt, m_done_cnt, m_k, m_index;

  function automatic logic [31:0] ref_step(input logic [31:0] v);
    logic [31:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  // Inverse-CDF pick: target = floor(r*total / 2^W), first item whose prefix sum exceeds it.
  function automatic void ref_pick(input logic [31:0] r, output int k, output bit zero);
    logic [127:0] total, target, acc, rr;
    total = 0;
    for (int i = 0; i < NI; i++) total += 128'(m_w[i]);
    zero = (total == 0);
    k = 0;
    if (!zero) begin
      rr = 128'(r);
      target = (rr * total) >> W;
      acc = 0;
      k = -1;
      for (int i = 0; i < NI; i++) begin
        acc += 128'(m_w[i]);
        if (k < 0 && target < acc) k = i;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 32'd1; m_busy = 0; m_valid = 0; m_error = 0; m_zero = 0;
      m_index = 0; m_cnt = 0; m_done_cnt = 1000; m_k = 0;
    end else begin
      m_r = m_lfsr;
      if (rc_if.in_seed_load) m_lfsr = (rc_if.in_seed == 0) ? 32'd1 : rc_if.in_seed;
      else if (rc_if.in_enable) m_lfsr = ref_step(m_lfsr);
      if (rc_if.in_enable) begin
        if (m_valid) begin
          m_valid = 0;
          m_busy  = 0;
        end else if (!m_busy) begin
          if (rc_if.in_start) begin
            m_busy = 1; m_cnt = 0; m_done_cnt = 1000;
            for (int i = 0; i < NI; i++) begin
              m_w[i] = longint'(rc_if.in_weights[i*W +: W]);
`ifdef RC_ITEM_MASK_EN
              if (!rc_if.in_mask[i]) m_w[i] = 0;
`endif
            end
          end
        end else begin
          m_cnt++;
          if (m_cnt == NI + 1) begin
            ref_pick(m_r, m_k, m_zero);
            m_done_cnt = NI + 2 + m_k;
          end
          if (m_cnt == m_done_cnt) begin
            m_valid = 1;
            m_index = m_k;
            m_error = m_zero;
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cycle_outputs",
            {60'd0, rc_if.out_busy, rc_if.out_valid, rc_if.out_error, rc_if.out_index},
            {60'd0, m_busy, m_valid, m_error, IDXW'(m_index)});
    end
  end

  // ---------------- driver ----------------
  function automatic logic [NI*W-1:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Called just after a negedge with the DUT idle. Edge 1 is the start edge; lat is
  // the number of edges until out_valid is seen. in_start stays high (ignored while busy).
  task automatic run_draw(input logic [NI*W-1:0] w, input int seed_edge, input logic [31:0] seed,
                          input int stall_at, input int stall_len, input int done_stall,
                          output int lat, output int idx, output bit err);
    bit got;
    got = 0; lat = 0; idx = -1; err = 0;
    rc_if.in_weights   = w;
    rc_if.in_seed      = seed;
    rc_if.in_seed_load = (seed_edge == 1);
    rc_if.in_start     = 1'b1;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      rc_if.in_weights   = {$urandom, $urandom, $urandom, $urandom};
      rc_if.in_seed_load = (lat + 1 == seed_edge);
      if (stall_len > 0 && lat == stall_at) rc_if.in_enable = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) rc_if.in_enable = 1'b1;
      if (rc_if.out_valid) begin
        got = 1;
        idx = int'(rc_if.out_index);
        err = rc_if.out_error;
        rc_if.in_start = 1'b0;
      end
    end
    rc_if.in_start = 1'b0;
    rc_if.in_seed_load = 1'b0;
    if (!got) begin
      check("draw_timeout", 64'd0, 64'd1);
      rc_if.in_enable = 1'b1;
    end else begin
      if (done_stall > 0) begin
        rc_if.in_enable = 1'b0;
        repeat (done_stall) begin
          @(posedge clk);
          @(negedge clk);
          check("done_hold_valid", 64'(rc_if.out_valid), 64'd1);
        end
        rc_if.in_enable = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  int lat, idx, cnt [NI];
  bit err;
  logic [NI*W-1:0] w2420;

  initial begin
    rst = 1'b1;
    rc_if.in_enable = 1'b1; rc_if.in_seed_load = 1'b0; rc_if.in_seed = 32'd0;
    rc_if.in_start = 1'b0; rc_if.in_weights = '0;
`ifdef RC_ITEM_MASK_EN
    rc_if.in_mask = '1;
`endif
    w2420 = pack4(2, 4, 2, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(rc_if.out_busy), 64'd0);
    check("reset_valid", 64'(rc_if.out_valid), 64'd0);
    check("reset_index", 64'(rc_if.out_index), 64'd0);
    check("reset_error", 64'(rc_if.out_error), 64'd0);
    check("reset_state", 64'(rc_if.dbg_state), 64'(IDLE));
    cmp_on = 1;
    rst = 1'b0;
    @(negedge clk);

    // Only item 3 weighted: always index 3, worst-case latency 2N+2.
    for (int n = 0; n < 3; n++) begin
      run_draw(pack4(0, 0, 0, 5), -1, 0, 0, 0, 0, lat, idx, err);
      check("w3_only_index", 64'(idx), 64'd3);
      check("w3_only_latency", 64'(lat), 64'd10);
    end

    // All-zero weights: error result after N+3 edges.
    run_draw(pack4(0, 0, 0, 0), -1, 0, 0, 0, 0, lat, idx, err);
    check("zero_error", 64'(err), 64'd1);
    check("zero_index", 64'(idx), 64'd0);
    check("zero_latency", 64'(lat), 64'd7);

    // Hand-computed LFSR draws with weights 2,4,2,0 (cum 2,6,8,8).
    run_draw(w2420, 1, 32'h0000_0010, 0, 0, 0, lat, idx, err);  // r=1 -> target 0
    check("seed10_index", 64'(idx), 64'd0);
    check("seed10_latency", 64'(lat), 64'd7);
    run_draw(w2420, 1, 32'h0000_0008, 0, 0, 0, lat, idx, err);  // r=0x80200003 -> 4
    check("seed08_index", 64'(idx), 64'd1);
    check("seed08_latency", 64'(lat), 64'd8);
    run_draw(w2420, 1, 32'h0000_0000, 0, 0, 0, lat, idx, err);  // seed 0 -> 1, r=0xB02C0003 -> 5
    check("seed00_index", 64'(idx), 64'd1);
    check("seed00_latency", 64'(lat), 64'd8);
    run_draw(w2420, 4, 32'h8000_0003, 0, 0, 0, lat, idx, err);  // load while busy, r=0xC0200002 -> 6
    check("seedbusy_index", 64'(idx), 64'd2);
    check("seedbusy_latency", 64'(lat), 64'd9);
    check("seedbusy_error", 64'(err), 64'd0);

    // Seed load while stalled, then a draw: start edge plus 4 steps from 0x10.
    rc_if.in_enable = 1'b0; rc_if.in_seed_load = 1'b1; rc_if.in_seed = 32'h10;
    @(posedge clk);
    @(negedge clk);
    check("stalled_seed_idle", 64'(rc_if.out_busy), 64'd0);
    rc_if.in_enable = 1'b1; rc_if.in_seed_load = 1'b0;
    run_draw(w2420, -1, 0, 0, 0, 0, lat, idx, err);
    check("stalled_seed_index", 64'(idx), 64'd1);
    check("stalled_seed_latency", 64'(lat), 64'd8);

    // Stall 3 cycles in SEARCH, then 3 cycles in DONE.
    run_draw(pack4(0, 0, 0, 5), -1, 0, 8, 3, 3, lat, idx, err);
    check("stall_index", 64'(idx), 64'd3);
    check("stall_latency", 64'(lat), 64'd13);

    // Reset pulse mid-ACCUM: no result, then a normal draw.
    rc_if.in_weights = w2420; rc_if.in_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rc_if.in_start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midreset_busy", 64'(rc_if.out_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("midreset_no_valid", 64'({rc_if.out_valid, rc_if.out_busy}), 64'd0);
    end
    run_draw(w2420, 1, 32'h0000_0010, 0, 0, 0, lat, idx, err);
    check("after_reset_index", 64'(idx), 64'd0);
    check("after_reset_latency", 64'(lat), 64'd7);

`ifdef RC_ITEM_MASK_EN
    rc_if.in_mask = 4'b1011;
    for (int i = 0; i < NI; i++) cnt[i] = 0;
    for (int n = 0; n < 200; n++) begin
      run_draw(pack4(1, 1, 1, 1), -1, 0, 0, 0, 0, lat, idx, err);
      if (idx >= 0 && idx < NI) cnt[idx]++;
    end
    check("mask_item2_count", 64'(cnt[2]), 64'd0);
    rc_if.in_mask = '1;
`endif

    // Distribution: seed 1, weights 2,4,2,0, 8000 draws.
    for (int i = 0; i < NI; i++) cnt[i] = 0;
    for (int n = 0; n < 8000; n++) begin
      run_draw(w2420, (n == 0) ? 1 : -1, 32'd1, 0, 0, 0, lat, idx, err);
      if (idx >= 0 && idx < NI) begin
        cnt[idx]++;
        check("dist_latency", 64'(lat), 64'(NI + 3 + idx));
      end
    end
    check("dist_item0", 64'(cnt[0] >= 1600 && cnt[0] <= 2400), 64'd1);
    check("dist_item1", 64'(cnt[1] >= 3600 && cnt[1] <= 4400), 64'd1);
    check("dist_item2", 64'(cnt[2] >= 1600 && cnt[2] <= 2400), 64'd1);
    check("dist_item3_zero", 64'(cnt[3]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
